// File: rtl/axi4_stream_pkt.sv
// AXI4-Stream register slice (main + skid) that tags packet boundaries
// from a programmable length or upstream TLAST, and counts packets.
module axi4_stream_pkt #(
    parameter int  DN = 1,
    parameter type DT = logic signed [8-1:0],
    parameter int  CW = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    ctl_rst,
    input  logic [CW-1:0]           cfg_len,
    output logic [CW-1:0]           sts_cnt,
    output logic [31:0]             sts_pkt,
    input  logic [DN*$bits(DT)-1:0] sti_TDATA,
    input  logic [DN-1:0]           sti_TKEEP,
    input  logic                    sti_TLAST,
    input  logic                    sti_TVALID,
    output logic                    sti_TREADY,
    output logic [DN*$bits(DT)-1:0] sto_TDATA,
    output logic [DN-1:0]           sto_TKEEP,
    output logic                    sto_TLAST,
    output logic                    sto_TVALID,
    input  logic                    sto_TREADY
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t                    state;
    logic [CW-1:0]             len_q;
    logic                      skid_v;
    logic [DN*$bits(DT)-1:0]   skid_d;
    logic [DN-1:0]             skid_k;
    logic                      skid_l;
    logic                      in_xfer;
    logic                      free;
    logic                      tag;

    assign in_xfer = sti_TVALID & sti_TREADY;
    // main can take a new beat when empty or handing its beat off this cycle
    assign free    = ~sto_TVALID | sto_TREADY;
    assign tag     = (sts_cnt == ((state == IDLE) ? cfg_len : len_q))
                   | sti_TLAST;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            len_q      <= '0;
            sts_cnt    <= '0;
            sts_pkt    <= '0;
            sti_TREADY <= 1'b0;
            sto_TVALID <= 1'b0;
            sto_TDATA  <= '0;
            sto_TKEEP  <= '0;
            sto_TLAST  <= 1'b0;
            skid_v     <= 1'b0;
            skid_d     <= '0;
            skid_k     <= '0;
            skid_l     <= 1'b0;
        end else if (ctl_rst) begin
            state      <= IDLE;
            len_q      <= cfg_len;
            sts_cnt    <= '0;
            sts_pkt    <= '0;
            sti_TREADY <= 1'b1;
            sto_TVALID <= 1'b0;
            skid_v     <= 1'b0;
        end else begin
            if (free) begin
                sti_TREADY <= 1'b1;
                if (skid_v) begin
                    // ready was low, so no new beat can arrive here
                    sto_TVALID <= 1'b1;
                    sto_TDATA  <= skid_d;
                    sto_TKEEP  <= skid_k;
                    sto_TLAST  <= skid_l;
                    skid_v     <= 1'b0;
                end else begin
                    sto_TVALID <= in_xfer;
                    if (in_xfer) begin
                        sto_TDATA <= sti_TDATA;
                        sto_TKEEP <= sti_TKEEP;
                        sto_TLAST <= tag;
                    end
                end
            end else if (in_xfer) begin
                skid_v     <= 1'b1;
                skid_d     <= sti_TDATA;
                skid_k     <= sti_TKEEP;
                skid_l     <= tag;
                sti_TREADY <= 1'b0;
            end

            if (state == IDLE) begin
                len_q <= cfg_len;
            end

            if (in_xfer) begin
                if (tag) begin
                    state   <= IDLE;
                    sts_cnt <= '0;
                    sts_pkt <= sts_pkt + 32'd1;
                end else begin
                    state   <= PKT;
                    sts_cnt <= sts_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_stream_pkt.sv
// Scoreboard bench for axi4_stream_pkt: directed packets, stalls,
// early TLAST, length changes, soft and hard reset.
module tb_axi4_stream_pkt;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ctl_rst;
    logic [15:0] cfg_len;
    logic [15:0] sts_cnt;
    logic [31:0] sts_pkt;
    logic [7:0]  sti_TDATA;
    logic [0:0]  sti_TKEEP;
    logic        sti_TLAST;
    logic        sti_TVALID;
    logic        sti_TREADY;
    logic [7:0]  sto_TDATA;
    logic [0:0]  sto_TKEEP;
    logic        sto_TLAST;
    logic        sto_TVALID;
    logic        sto_TREADY;

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    ncmp = 0;
    int    nerr = 0;
    int    lo_cnt = 0;
    bit    lo_en = 1'b0;

    axi4_stream_pkt dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .ctl_rst    (ctl_rst),
        .cfg_len    (cfg_len),
        .sts_cnt    (sts_cnt),
        .sts_pkt    (sts_pkt),
        .sti_TDATA  (sti_TDATA),
        .sti_TKEEP  (sti_TKEEP),
        .sti_TLAST  (sti_TLAST),
        .sti_TVALID (sti_TVALID),
        .sti_TREADY (sti_TREADY),
        .sto_TDATA  (sto_TDATA),
        .sto_TKEEP  (sto_TKEEP),
        .sto_TLAST  (sto_TLAST),
        .sto_TVALID (sto_TVALID),
        .sto_TREADY (sto_TREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit    hold = 1'b0;
        beat_t hb;
        beat_t got;
        beat_t e;
        forever begin
            @(negedge ACLK);
            got = '{d: sto_TDATA, k: sto_TKEEP[0], l: sto_TLAST};
            if (hold && ARESETn)
                chk("hold", {21'd0, sto_TVALID, got}, {21'd0, 1'b1, hb});
            hold = sto_TVALID && !sto_TREADY && !ctl_rst && ARESETn;
            hb   = got;
            if (ARESETn && sto_TVALID && sto_TREADY) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", {22'd0, got}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {22'd0, got}, {22'd0, e});
                end
            end
            if (lo_en && ARESETn && !sti_TREADY) lo_cnt++;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k,
                             input logic tl, input logic el,
                             input bit push);
        sti_TDATA  = d;
        sti_TKEEP  = k;
        sti_TLAST  = tl;
        sti_TVALID = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge ACLK);
            if (sti_TREADY) begin
                if (push) exp_q.push_back('{d: d, k: k, l: el});
                @(posedge ACLK);
                #1;
                return;
            end
        end
        chk("sti_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++)
            @(negedge ACLK);
        chk("drain", exp_q.size(), 32'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_tvalid", {31'd0, sto_TVALID}, 32'd0);
        chk("rst_tready", {31'd0, sti_TREADY}, 32'd0);
        chk("rst_cnt", {16'd0, sts_cnt}, 32'd0);
        chk("rst_pkt", sts_pkt, 32'd0);
        chk("rst_tlast", {31'd0, sto_TLAST}, 32'd0);
        chk("rst_tdata", {24'd0, sto_TDATA}, 32'd0);
        chk("rst_tkeep", {31'd0, sto_TKEEP}, 32'd0);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] d;
        ARESETn    = 1'b0;
        ctl_rst    = 1'b0;
        cfg_len    = 16'd3;
        sti_TDATA  = '0;
        sti_TKEEP  = '0;
        sti_TLAST  = 1'b0;
        sti_TVALID = 1'b0;
        sto_TREADY = 1'b1;
        fork
            monitor();
        join_none

        repeat (3) @(negedge ACLK);
        chk_reset_outs();
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        chk("ready_after_rst", {31'd0, sti_TREADY}, 32'd1);

        // 8 beats, length 4: last on beats 3 and 7
        m = 8'b1000_1000;
        for (int i = 0; i < 8; i++) begin
            d = 8'(i);
            send_beat(d, ~d[0], 1'b0, m[i], 1'b1);
            if (i == 0) begin
                chk("lat_valid", {31'd0, sto_TVALID}, 32'd1);
                chk("lat_data", {24'd0, sto_TDATA}, 32'd0);
            end
        end
        sti_TVALID = 1'b0;
        drain();
        chk("pkt_t1", sts_pkt, 32'd2);
        chk("cnt_t1", {16'd0, sts_cnt}, 32'd0);

        // downstream stall of 3 cycles mid-stream
        lo_cnt = 0;
        lo_en  = 1'b1;
        fork
            for (int i = 0; i < 8; i++) begin
                d = 8'h10 + 8'(i);
                send_beat(d, d[0], 1'b0, m[i], 1'b1);
            end
            begin
                repeat (2) @(posedge ACLK);
                #1 sto_TREADY = 1'b0;
                repeat (3) @(posedge ACLK);
                #1 sto_TREADY = 1'b1;
            end
        join
        sti_TVALID = 1'b0;
        drain();
        lo_en = 1'b0;
        chk("stall_lo_cycles", lo_cnt, 32'd3);
        chk("pkt_t2", sts_pkt, 32'd4);

        // early upstream TLAST, then a full 8-beat packet
        cfg_len = 16'd7;
        send_beat(8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
        send_beat(8'h22, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("cnt_early", {16'd0, sts_cnt}, 32'd0);
        for (int i = 0; i < 8; i++)
            send_beat(8'h30 + 8'(i), 1'b1, 1'b0, (i == 7), 1'b1);
        sti_TVALID = 1'b0;
        drain();
        chk("pkt_t3", sts_pkt, 32'd6);

        // length 1: every beat closes a packet
        cfg_len = 16'd0;
        for (int i = 0; i < 4; i++) begin
            send_beat(8'h40 + 8'(i), 1'b1, 1'b0, 1'b1, 1'b1);
            chk("pkt_len1", sts_pkt, 32'(7 + i));
        end
        sti_TVALID = 1'b0;
        drain();

        // length change mid-packet only applies from the next packet
        cfg_len = 16'd3;
        send_beat(8'h50, 1'b1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h51, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_mid", {16'd0, sts_cnt}, 32'd2);
        cfg_len = 16'd1;
        send_beat(8'h52, 1'b1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h53, 1'b0, 1'b0, 1'b1, 1'b1);
        send_beat(8'h54, 1'b1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
        sti_TVALID = 1'b0;
        drain();
        chk("pkt_t5", sts_pkt, 32'd12);

        // soft reset with main and skid both full
        cfg_len    = 16'd3;
        sto_TREADY = 1'b0;
        send_beat(8'h60, 1'b1, 1'b0, 1'b0, 1'b0);
        send_beat(8'h61, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("skid_full_rdy", {31'd0, sti_TREADY}, 32'd0);
        sti_TDATA = 8'h62;
        ctl_rst   = 1'b1;
        @(posedge ACLK);
        #1;
        chk("srst_tvalid", {31'd0, sto_TVALID}, 32'd0);
        chk("srst_cnt", {16'd0, sts_cnt}, 32'd0);
        chk("srst_pkt", sts_pkt, 32'd0);
        chk("srst_tready", {31'd0, sti_TREADY}, 32'd1);
        @(posedge ACLK);
        #1;
        chk("srst_drop_valid", {31'd0, sto_TVALID}, 32'd0);
        chk("srst_drop_cnt", {16'd0, sts_cnt}, 32'd0);
        ctl_rst    = 1'b0;
        sti_TVALID = 1'b0;
        sto_TREADY = 1'b1;
        for (int i = 0; i < 4; i++)
            send_beat(8'h70 + 8'(i), 1'b1, 1'b0, (i == 3), 1'b1);
        sti_TVALID = 1'b0;
        drain();
        chk("pkt_after_srst", sts_pkt, 32'd1);

        // asynchronous reset mid-packet with data buffered
        sto_TREADY = 1'b0;
        send_beat(8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        send_beat(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        sti_TVALID = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        chk_reset_outs();
        @(negedge ACLK);
        ARESETn    = 1'b1;
        sto_TREADY = 1'b1;
        @(posedge ACLK);
        #1;
        chk("ready_after_arst", {31'd0, sti_TREADY}, 32'd1);
        cfg_len = 16'd1;
        send_beat(8'h90, 1'b1, 1'b0, 1'b0, 1'b1);
        send_beat(8'h91, 1'b1, 1'b0, 1'b1, 1'b1);
        sti_TVALID = 1'b0;
        drain();
        chk("pkt_after_arst", sts_pkt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
